// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: round-robin sequencer for the shared WIDTH-bit ripple adder.
// Accepts multi-word add requests from two requesters and feeds the adder
// one word per cycle, least-significant word first, chaining the carry.
// The full-width sum is returned on a held response channel.
//
// Handshake semantics (all channels): a transfer happens on the rising edge
// where valid && ready are both high. A producer holds its payload stable
// while valid is high and unaccepted; reqN_ready is combinational and only
// high in IDLE for the requester granted that cycle; rsp_valid is held with
// stable rsp_data/rsp_cout/rsp_id until rsp_ready is seen.
module adder_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [WIDTH*WORDS-1:0] req0_a,
  input  logic [WIDTH*WORDS-1:0] req0_b,
  input  logic                   req0_cin,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [WIDTH*WORDS-1:0] req1_a,
  input  logic [WIDTH*WORDS-1:0] req1_b,
  input  logic                   req1_cin,
  output logic [WIDTH-1:0]       add_in0,
  output logic [WIDTH-1:0]       add_in1,
  output logic                   add_cin,
  input  logic [WIDTH-1:0]       add_out,
  input  logic                   add_cout,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH*WORDS-1:0] rsp_data,
  output logic                   rsp_cout,
  output logic                   rsp_id,
  output logic                   busy
);

  localparam int OPW  = WIDTH * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [OPW-1:0]  a_q, b_q;
  logic            carry_q;
  logic [IDXW-1:0] idx_q;
  logic            last_q;      // requester granted most recently
  logic            grant_valid;
  logic            grant_id;
  logic            accept;

  // Round-robin choice: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = ~last_q;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  // Next-state and output decode; adder inputs are zero outside RUN.
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    add_in0    = '0;
    add_in1    = '0;
    add_cin    = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          accept     = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        add_in0 = a_q[int'(idx_q)*WIDTH +: WIDTH];
        add_in1 = b_q[int'(idx_q)*WIDTH +: WIDTH];
        add_cin = carry_q;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand capture on accept, and per-word result/carry accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      last_q   <= 1'b1;   // makes req0 win the first tie
      rsp_data <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= grant_id ? req1_a : req0_a;
        b_q     <= grant_id ? req1_b : req0_b;
        carry_q <= grant_id ? req1_cin : req0_cin;
        idx_q   <= '0;
        last_q  <= grant_id;
        rsp_id  <= grant_id;
      end
      if (state_q == RUN) begin
        rsp_data[int'(idx_q)*WIDTH +: WIDTH] <= add_out;
        carry_q <= add_cout;
        idx_q   <= idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) rsp_cout <= add_cout;
      end
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: models the attached ripple adder, drives directed
// requests, and checks responses against a queue of hand-computed results.
module tb_adder_seq_ctrl;

  localparam int WIDTH = 16;
  localparam int WORDS = 4;
  localparam int OPW   = WIDTH * WORDS;
  localparam int EW    = OPW + 2;   // {id, cout, data}

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req0_ready, req0_cin;
  logic [OPW-1:0]   req0_a, req0_b;
  logic             req1_valid, req1_ready, req1_cin;
  logic [OPW-1:0]   req1_a, req1_b;
  logic [WIDTH-1:0] add_in0, add_in1, add_out;
  logic             add_cin, add_cout;
  logic             rsp_valid, rsp_ready, rsp_cout, rsp_id, busy;
  logic [OPW-1:0]   rsp_data;

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  adder_seq_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_cin(req1_cin),
    .add_in0(add_in0), .add_in1(add_in1), .add_cin(add_cin),
    .add_out(add_out), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_cout(rsp_cout), .rsp_id(rsp_id), .busy(busy)
  );

  // Shared combinational ripple adder.
  assign {add_cout, add_out} = {1'b0, add_in0} + {1'b0, add_in1} + {{WIDTH{1'b0}}, add_cin};

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Driver: present a request and hold it until accepted; returns just after the accept edge.
  task automatic send(input bit id, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                      input logic cin, input bit drop);
    bit got;
    if (id == 1'b0) begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
    end
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if ((id == 1'b0) ? req0_ready : req1_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout req%0d ready=0 required=1", id);
    end
    @(posedge clk); #1;
    if (drop) begin
      if (id == 1'b0) req0_valid = 1'b0;
      else            req1_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("wait_idle_busy", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  // Single op with rsp_ready high: checks carry-in per RUN cycle and latency.
  task automatic run_op(input string name, input bit id, input logic [OPW-1:0] a,
                        input logic [OPW-1:0] b, input logic cin, input logic [3:0] cin_seq);
    send(id, a, b, cin, 1'b1);
    for (int c = 0; c < WORDS; c++) begin
      @(negedge clk);
      chk({name, "_run_valid"}, rsp_valid, 1'b0);
      chk({name, "_add_cin"}, add_cin, cin_seq[c]);
    end
    @(negedge clk);
    chk({name, "_latency_valid"}, rsp_valid, 1'b1);
    wait_idle();
  endtask

  // Scoreboard monitor: pops one expectation per response handshake.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id",   rsp_id,   e[OPW+1]);
        chk("rsp_cout", rsp_cout, e[OPW]);
        chk("rsp_data", rsp_data, e[OPW-1:0]);
      end
    end
  end

  // At most one ready per cycle.
  always @(negedge clk) begin
    if (req0_ready || req1_ready) chk("ready_onehot", req0_ready & req1_ready, 1'b0);
  end

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_rsp_cout", rsp_cout, 1'b0);
    chk("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_add_in0", add_in0, '0);
    chk("rst_add_cin", add_cin, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic: 1 + 1 + 1
    exp_q.push_back({1'b0, 1'b0, 64'h0000_0000_0000_0003});
    run_op("basic", 1'b0, 64'd1, 64'd1, 1'b1, 4'b0001);

    // Carry crossing word 0 -> word 1
    exp_q.push_back({1'b0, 1'b0, 64'h0000_0000_0001_0000});
    run_op("xword", 1'b0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 4'b0010);

    // Full wrap
    exp_q.push_back({1'b0, 1'b1, 64'h0000_0000_0000_0000});
    run_op("wrap", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 4'b1111);

    // Back-pressure on the response channel (req1: 5 + 7 = 12)
    rsp_ready = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 64'd12});
    send(1'b1, 64'd5, 64'd7, 1'b0, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk("bp_valid_seen", rsp_valid, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 64'd9; req0_b = 64'd9; req0_cin = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rsp_data", rsp_data, 64'd12);
      chk("bp_rsp_id", rsp_id, 1'b1);
      chk("bp_req0_ready", req0_ready, 1'b0);
      chk("bp_req1_ready", req1_ready, 1'b0);
      chk("bp_busy", busy, 1'b1);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", rsp_valid, 1'b1);
    @(negedge clk);
    chk("bp_after_busy", busy, 1'b0);
    chk("bp_after_valid", rsp_valid, 1'b0);
    chk("bp_after_data_held", rsp_data, 64'd12);
    chk("bp_after_id_held", rsp_id, 1'b1);
    @(posedge clk); #1;

    // Fairness: both requesters held valid, grant order 0,1,0,1
    exp_q.push_back({1'b0, 1'b0, 64'h0000_0000_0000_0030});
    exp_q.push_back({1'b1, 1'b1, 64'h0000_0000_0000_0000});
    exp_q.push_back({1'b0, 1'b0, 64'h2345_6789_ABCD_F002});
    exp_q.push_back({1'b1, 1'b0, 64'h0001_0000_0001_0000});
    fork
      begin
        send(1'b0, 64'h10, 64'h20, 1'b0, 1'b0);
        send(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1, 1'b1);
      end
      begin
        send(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        send(1'b1, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b1);
      end
    join
    wait_idle();

    // Reset during RUN cycle 2 discards the op
    send(1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b1, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_rsp_valid", rsp_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_add_in0", add_in0, '0);
    chk("mrst_add_in1", add_in1, '0);
    chk("mrst_add_cin", add_cin, 1'b0);
    chk("mrst_rsp_data", rsp_data, '0);
    @(posedge clk); #1;

    // Tie after reset: req0 first
    exp_q.push_back({1'b0, 1'b0, 64'd7});
    exp_q.push_back({1'b1, 1'b0, 64'h0000_0001_0000_0000});
    fork
      send(1'b0, 64'd3, 64'd4, 1'b0, 1'b1);
      send(1'b1, 64'h0000_0000_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0, 1'b1);
    join
    wait_idle();

    for (int c = 0; c < 20; c++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
Sequencer and arbiter for the team's shared 16-bit ripple adder (in0/in1/cin -> out/cout, purely combinational). It accepts multi-word add requests from two requesters, arbitrates round-robin, and drives the adder one word per cycle, least-significant word first, chaining carry. The full-width sum and carry-out are returned on a held response channel. It sits between the execute-stage clients and the single physical adder instance.

Parameters:
WIDTH, 16, adder word width in bits; must match the attached adder.
WORDS, 4, words per operand; operand width = WIDTH*WORDS (64 by default); WORDS >= 1.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
req0_valid  input  1  requester 0 has an operation pending.
req0_ready  output  1  requester 0 accepted this cycle when valid&&ready.
req0_a  input  WIDTH*WORDS  operand A, requester 0.
req0_b  input  WIDTH*WORDS  operand B, requester 0.
req0_cin  input  1  carry-in, requester 0.
req1_valid  input  1  as req0_valid, requester 1.
req1_ready  output  1  as req0_ready, requester 1.
req1_a  input  WIDTH*WORDS  operand A, requester 1.
req1_b  input  WIDTH*WORDS  operand B, requester 1.
req1_cin  input  1  carry-in, requester 1.
add_in0  output  WIDTH  to adder in0.
add_in1  output  WIDTH  to adder in1.
add_cin  output  1  to adder cin.
add_out  input  WIDTH  from adder out (same-cycle combinational).
add_cout  input  1  from adder cout.
rsp_valid  output  1  result available.
rsp_ready  input  1  consumer takes result when valid&&ready.
rsp_data  output  WIDTH*WORDS  sum modulo 2^(WIDTH*WORDS).
rsp_cout  output  1  carry out of most-significant word.
rsp_id  output  1  requester index that owns rsp_data.
busy  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE. Reset -> IDLE.
- Reset values: rsp_valid=0, rsp_data=0, rsp_cout=0, rsp_id=0, busy=0, round-robin pointer favours req0, word index=0, carry register=0.
- reqN_ready is combinational: high only in IDLE for the requester granted this cycle, otherwise low. At most one ready is high per cycle.
- Arbitration in IDLE: only one valid -> grant it. Both valid -> grant the requester not granted last. After reset, req0 wins the first tie.
- Accept (IDLE, granted valid&&ready): latch a, b, cin, and id; set idx=0, carry=cin; set pointer=id; go to RUN.
- RUN, each cycle: add_in0=a[idx], add_in1=b[idx], add_cin=carry, where word idx is bits [idx*WIDTH +: WIDTH]. At the clock edge, store add_out into result word idx, set carry<=add_cout, idx<=idx+1. When idx==WORDS-1, go to DONE instead.
- Outside RUN, add_in0, add_in1 and add_cin are driven 0.
- DONE: rsp_valid=1. rsp_data, rsp_cout and rsp_id hold stable until rsp_valid&&rsp_ready, then go to IDLE. No new request is accepted before then. rsp_data/rsp_cout/rsp_id keep their last values after the handshake; only rsp_valid drops.
- Latency: accept at edge T; rsp_valid is high from cycle T+WORDS (WORDS RUN cycles). Earliest next accept is the cycle after the response handshake (no overlap).
- Arithmetic: the result wraps modulo 2^(WIDTH*WORDS); overflow is reported only via rsp_cout. WORDS=1 gives one RUN cycle.
- Requesters may change operands or drop valid while not accepted; the block samples only on the accept edge.
- Reset mid-operation (RUN or DONE): the in-flight op is discarded with no response. All registers return to reset values on that edge, and the pointer resets to favour req0.

Test Plan:
- Basic: req0 a=1, b=1, cin=1, rsp_ready=1 -> rsp_data=0x0000_0000_0000_0003, rsp_cout=0, rsp_id=0, rsp_valid exactly 4 cycles after accept; add_cin observed 1,0,0,0.
- Cross-word carry: a=0x0000_0000_0000_FFFF, b=1, cin=0 -> rsp_data=0x0000_0000_0001_0000, rsp_cout=0; add_cin high in the second RUN cycle.
- Full wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> rsp_data=0, rsp_cout=1.
- Fairness: req0 and req1 both held valid for 4 ops with distinct operands -> grant order 0,1,0,1; each rsp_id matches its operands; req0_ready and req1_ready never high together.
- Back-pressure: rsp_ready low for 3 cycles in DONE -> rsp_valid, rsp_data and rsp_id stable, both readys low, busy=1; completes on the first cycle rsp_ready=1, then IDLE.
- Reset mid-RUN: rst_n low for one edge during RUN cycle 2 -> next cycle rsp_valid=0, busy=0, add_in*=0; with a tie afterwards, req0 is granted first.
